// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and constants for the multi-cycle MIPS controller
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    typedef logic [5:0] opcode_t;
    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/mc_alu_dec.sv
// rtl/mc_alu_dec.sv - combinational ALU decoder from ALU op class and funct field
module mc_alu_dec
    import mc_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // Fixed add/sub classes pass through; the funct class decodes R-type ops, unknowns fall back to add
    always_comb begin
        alu_control = ALUC_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALUC_ADD;
                    FN_SUB:  alu_control = ALUC_SUB;
                    FN_AND:  alu_control = ALUC_AND;
                    FN_OR:   alu_control = ALUC_OR;
                    FN_SLT:  alu_control = ALUC_SLT;
                    default: alu_control = ALUC_ADD;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS main controller Moore FSM with memory stall handshake
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int ALUC_W  = 3,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [ALUC_W-1:0]  alu_control,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_o
);

    state_t  state_q, state_d;
    alu_op_t alu_op;
    logic    pc_write;
    logic    branch;

    // State register; reset wins over every pending transition or memory wait
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state and Moore output decode; reset forces enables off and selects to their fetch values
    always_comb begin
        state_d    = S_FETCH;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JEX: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        pc_en = pc_write | (branch & zero);

        if (rst) begin
            pc_en      = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
            iord       = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b01;
            pc_src     = 2'b00;
        end
    end

    mc_alu_dec u_alu_dec (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

    assign state_o = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed self-checking bench for mc_control_fsm
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state_o;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                           MEMWB = 4'd4, MEMWR = 4'd5, RTYPEEX = 4'd6, RTYPEWB = 4'd7,
                           BEQEX = 4'd8, JEX = 4'd11;

    mc_control_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .illegal_op  (illegal_op),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH with memory ready, move into DECODE with the given instruction fields
    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        opcode    = op;
        funct     = fn;
        mem_ready = 1'b1;
        #1;
        check("fetch_state", state_o, FETCH);
        tick();
        check("decode_state", state_o, DECODE);
    endtask

    logic [5:0] fn_tab  [3];
    logic [2:0] exp_tab [3];

    initial begin
        rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

        // 1. reset
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_state", state_o, FETCH);
            check("rst_enables", {pc_en, ir_write, mem_write, reg_write, illegal_op}, 5'b0);
            check("rst_selects", {iord, alu_src_a, alu_src_b, pc_src}, 6'b000100);
        end
        rst = 1'b0;
        #1;
        check("fetch_ir_pc_en", {ir_write, pc_en}, 2'b11);
        check("fetch_alu_add", alu_control, 3'b010);

        // FETCH stalls while memory is not ready
        mem_ready = 1'b0;
        #1;
        check("fetch_stall_en", {ir_write, pc_en}, 2'b00);
        tick();
        check("fetch_stall_state", state_o, FETCH);

        // 2. lw with two stall cycles in MEMRD
        fetch(6'b100011, 6'd0);
        check("decode_srcb", alu_src_b, 2'b11);
        tick();
        check("lw_memadr", state_o, MEMADR);
        check("lw_memadr_sel", {alu_src_a, alu_src_b}, 3'b110);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ready = 1'b1;
            #1;
            check("lw_memrd", state_o, MEMRD);
            check("lw_memrd_iord_rw", {iord, reg_write}, 2'b10);
            tick();
        end
        check("lw_memwb", state_o, MEMWB);
        check("lw_memwb_ctl", {reg_write, mem_to_reg, reg_dst}, 3'b110);
        tick();
        check("lw_done", state_o, FETCH);
        check("lw_fetch_rw", reg_write, 1'b0);

        // 3. beq taken and not taken
        for (int z = 1; z >= 0; z--) begin
            fetch(6'b000100, 6'd0);
            tick();
            zero = z[0];
            #1;
            check("beq_state", state_o, BEQEX);
            check("beq_pc_en", pc_en, z[0]);
            check("beq_pc_src", pc_src, 2'b01);
            check("beq_sub", alu_control, 3'b110);
            tick();
            check("beq_done", state_o, FETCH);
        end
        zero = 1'b0;

        // 4. R-type funct decode
        fn_tab[0] = 6'b100100; exp_tab[0] = 3'b000;
        fn_tab[1] = 6'b101010; exp_tab[1] = 3'b111;
        fn_tab[2] = 6'b111111; exp_tab[2] = 3'b010;
        for (int k = 0; k < 3; k++) begin
            fetch(6'b000000, fn_tab[k]);
            tick();
            check("rt_ex_state", state_o, RTYPEEX);
            check("rt_alu_control", alu_control, exp_tab[k]);
            check("rt_ex_rw", reg_write, 1'b0);
            tick();
            check("rt_wb_state", state_o, RTYPEWB);
            check("rt_wb_ctl", {reg_dst, reg_write, mem_to_reg}, 3'b110);
            tick();
            check("rt_done", state_o, FETCH);
        end

        // 5. illegal opcode
        fetch(6'b111111, 6'd0);
        check("ill_pulse", illegal_op, 1'b1);
        check("ill_no_writes", {reg_write, mem_write, pc_en, ir_write}, 4'b0);
        tick();
        check("ill_next_fetch", state_o, FETCH);
        check("ill_pulse_end", illegal_op, 1'b0);

        // jump
        fetch(6'b000010, 6'd0);
        tick();
        check("j_state", state_o, JEX);
        check("j_ctl", {pc_en, pc_src}, 3'b110);
        tick();
        check("j_done", state_o, FETCH);

        // 6. sw with three stall cycles: mem_write held four cycles
        fetch(6'b101011, 6'd0);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            check("sw_memwr", state_o, MEMWR);
            check("sw_mem_write", {mem_write, iord}, 2'b11);
            tick();
        end
        check("sw_done", state_o, FETCH);
        check("sw_mw_off", mem_write, 1'b0);

        // reset during a pending store
        fetch(6'b101011, 6'd0);
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        check("swr_memwr", state_o, MEMWR);
        rst = 1'b1;
        #1;
        check("swr_mw_forced", {mem_write, iord, pc_en}, 3'b000);
        tick();
        check("swr_state", state_o, FETCH);
        check("swr_mw_rst", mem_write, 1'b0);
        rst = 1'b0;
        tick();
        check("swr_stay_fetch", state_o, FETCH);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
